ppt_uart_rx_display: RTL
========================

Name: ppt_uart_rx_display

Overview:
- UART 8N1 receiver for the presentation-controller tile.
- Takes status bytes sent by the host PC (e.g. the current slide number) and latches each good byte.
- Drives the on-board 7-segment display with the low nibble of that byte, in hex.
- It is the host-to-board direction, the counterpart of the switch-capture path toward the host.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit. Minimum 4; must be even.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- ena  input  1  tile enable; low holds the receiver in IDLE
- rx  input  1  asynchronous UART line, idles high
- rx_data  output  8  last correctly framed byte
- rx_valid  output  1  one-cycle pulse when rx_data updates
- frame_err  output  1  one-cycle pulse on a bad stop bit
- seg  output  7  segments a..g on seg[0]..seg[6], active-high, hex of rx_data[3:0]
- dp  output  1  sticky error indicator on the decimal point

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, dp=0.
  - seg=0x3F (glyph "0"); FSM in IDLE.
  - Synchronizer flops = 1.
- Input path: rx passes through a 2-flop synchronizer (both flops reset to 1). All FSM decisions use the synchronized value rxs.
- One bit counter counts to CLKS_PER_BIT-1, then reloads.
- States:
  - IDLE: when rxs=0 and ena=1 → START, counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, resample rxs.
    - 0 → DATA, bit index 0.
    - 1 → IDLE (glitch rejected, no output activity).
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift register, LSB first. After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - 1 → IDLE, with rx_data, rx_valid and seg updated on the next edge.
    - 0 → frame_err=1 for one cycle, rx_data/seg unchanged, dp set, → BREAK.
  - BREAK: wait until rxs=1, then → IDLE. No start detection while the line is held low.
- Good frame:
  - rx_valid pulses high for exactly one cycle.
  - rx_data and seg update on the same edge rx_valid rises.
  - dp clears on that same edge.
- Latency: rx_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the first clk edge that samples rx low.
- seg decode for nibble 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- ena deasserted mid-frame:
  - FSM returns to IDLE immediately; the partial byte is discarded.
  - No pulses are generated; rx_data, seg and dp hold.
- rst asserted mid-frame: all state returns to reset values asynchronously; no pulse is emitted after rst releases.
- Back-to-back frames: a new start bit may begin the cycle after STOP sampling. No extra idle bit is required.
- rx_valid and frame_err are never high in the same cycle.

Test Plan (CLKS_PER_BIT=8):
- Reset, then idle line → rx_data=0x00, seg=0x3F, dp=0, no pulses.
- Send 0x35 with a good stop bit → one rx_valid pulse at the specified latency, rx_data=0x35, seg=0x6D, dp=0.
- Send 0xA3 then 0x0F back-to-back → two rx_valid pulses, 10*8 cycles apart. Final rx_data=0x0F, seg=0x71.
- Send 0x12 with the stop bit low, then hold the line low for 40 cycles, then release → one frame_err pulse, no rx_valid, rx_data keeps its prior value, dp=1. Receiver re-arms only after the line goes high. A following good 0x07 gives seg=0x07 and dp=0.
- Low glitch of 2 cycles on the idle line → START rejects it, no pulses, state returns to IDLE.
- Drop ena after 3 data bits of 0x55, raise it again, then send 0x44 → no pulse for the aborted frame; rx_data=0x44, seg=0x66.

Source files
------------

// File: rtl/ppt_uart_rx_display.sv
// UART 8N1 receiver for the presentation-controller tile: latches each good byte
// and shows its low nibble as a hex glyph on the 7-segment display.
module ppt_uart_rx_display #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          good_pend;

  assign rxs = sync_q[1];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      good_pend <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      seg       <= 7'h3F;
      dp        <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_valid  <= good_pend;
      frame_err <= 1'b0;
      good_pend <= 1'b0;
      // Good stop bit is committed one edge after sampling, so data/seg/dp move with rx_valid.
      if (good_pend) begin
        rx_data <= shreg;
        seg     <= hex7(shreg[3:0]);
        dp      <= 1'b0;
      end
      if (!ena) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
          START: if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
          DATA: if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (cnt == LAST) begin
            cnt <= '0;
            if (rxs) begin
              good_pend <= 1'b1;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              dp        <= 1'b1;
              state     <= BRK;
            end
          end else cnt <= cnt + 1'b1;
          // Line held low after a bad stop: wait for idle before re-arming.
          BRK: if (rxs) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
